// File: rtl/paint_arbiter.sv
// Round-robin arbiter sharing the render_box24 painter between N_REQ draw requesters.
// Latches the winner's box command, pulses start, then waits for done or a watchdog timeout.
module paint_arbiter #(
  parameter int N_REQ = 3,
  parameter int TO_W  = 16
) (
  input  logic                 CLOCK_50,
  input  logic                 resetn,
  input  logic [N_REQ-1:0]     req,
  input  logic [10*N_REQ-1:0]  req_x0,
  input  logic [9*N_REQ-1:0]   req_y0,
  input  logic [9*N_REQ-1:0]   req_color,
  output logic [N_REQ-1:0]     ack,
  output logic [N_REQ-1:0]     cmp,
  output logic                 pnt_start,
  output logic [9:0]           pnt_x0,
  output logic [8:0]           pnt_y0,
  output logic [8:0]           pnt_color,
  input  logic                 pnt_busy,
  input  logic                 pnt_done,
  output logic [2:0]           owner,
  output logic                 active,
  output logic                 err_timeout
);

  typedef enum logic {IDLE, RUN} state_t;

  // One cycle before the counter would reach all-ones; the box ends on that edge.
  localparam logic [TO_W-1:0] WD_LAST = {{(TO_W-1){1'b1}}, 1'b0};

  state_t          state;
  logic [2:0]      rr_ptr;
  logic [TO_W-1:0] wd_cnt;

  logic       found;
  logic [2:0] win;
  logic [2:0] nxt_ptr;
  logic [9:0] sel_x0;
  logic [8:0] sel_y0;
  logic [8:0] sel_color;

  // Scan requests starting at rr_ptr, wrapping modulo N_REQ; first set bit wins.
  always_comb begin
    found   = 1'b0;
    win     = 3'd0;
    for (int off = 0; off < N_REQ; off++) begin
      int idx;
      idx = (int'(rr_ptr) + off) % N_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = 3'(idx);
      end
    end
    nxt_ptr   = 3'((int'(win) + 1) % N_REQ);
    sel_x0    = req_x0[int'(win)*10 +: 10];
    sel_y0    = req_y0[int'(win)*9 +: 9];
    sel_color = req_color[int'(win)*9 +: 9];
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      rr_ptr      <= 3'd0;
      wd_cnt      <= '0;
      ack         <= '0;
      cmp         <= '0;
      pnt_start   <= 1'b0;
      pnt_x0      <= 10'd0;
      pnt_y0      <= 9'd0;
      pnt_color   <= 9'd0;
      owner       <= 3'd0;
      active      <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      ack       <= '0;
      cmp       <= '0;
      pnt_start <= 1'b0;
      case (state)
        IDLE: begin
          if (found && !pnt_busy) begin
            pnt_x0    <= sel_x0;
            pnt_y0    <= sel_y0;
            pnt_color <= sel_color;
            ack       <= N_REQ'(1) << win;
            pnt_start <= 1'b1;
            owner     <= win;
            active    <= 1'b1;
            wd_cnt    <= '0;
            rr_ptr    <= nxt_ptr;
            state     <= RUN;
          end
        end
        RUN: begin
          // pnt_start still high marks the first RUN cycle, where a done is stale.
          if (pnt_done && !pnt_start) begin
            cmp    <= N_REQ'(1) << owner;
            active <= 1'b0;
            state  <= IDLE;
          end else if (wd_cnt == WD_LAST) begin
            wd_cnt      <= wd_cnt + 1'b1;
            err_timeout <= 1'b1;
            cmp         <= N_REQ'(1) << owner;
            active      <= 1'b0;
            state       <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
